// File: rtl/ram_ctrl_pkg.sv
// Shared constants, state encoding and RAM command encoding for the ram_ctrl
// controller and its address generator.
package ram_ctrl_pkg;

  localparam int unsigned DW         = 32;
  localparam int unsigned AW         = 8;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned DEPTH_LOG2 = $clog2(DEPTH);
  localparam int unsigned LEN_W      = 3;

  // Keeps addresses inside the implemented DEPTH words; upper address bits stay zero.
  localparam logic [AW-1:0] ADDR_MASK = AW'((1 << DEPTH_LOG2) - 1);

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_WR_BEAT  = 3'd2;
  localparam logic [2:0] ST_RD_ISSUE = 3'd3;
  localparam logic [2:0] ST_RD_WAIT  = 3'd4;
  localparam logic [2:0] ST_RD_RESP  = 3'd5;

  typedef enum logic [2:0] {
    S_INIT     = ST_INIT,
    S_IDLE     = ST_IDLE,
    S_WR_BEAT  = ST_WR_BEAT,
    S_RD_ISSUE = ST_RD_ISSUE,
    S_RD_WAIT  = ST_RD_WAIT,
    S_RD_RESP  = ST_RD_RESP
  } state_t;

endpackage

// File: rtl/ram_ctrl_addr_gen.sv
// Burst address generator: latched start address, modulo-DEPTH increment,
// beat counter and last-beat flag shared by the read, write and INIT paths.
module ram_ctrl_addr_gen
  import ram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [AW-1:0]    start,
  input  logic [LEN_W-1:0] len,
  output logic [AW-1:0]    cur_addr,
  output logic [AW-1:0]    next_addr_c,
  output logic             last_c
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;

  // Reset length covers the whole RAM so the INIT sweep terminates on last_c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr <= '0;
      cnt_q    <= '0;
      len_q    <= LEN_W'(DEPTH - 1);
    end else if (load) begin
      cur_addr <= start & ADDR_MASK;
      cnt_q    <= '0;
      len_q    <= len;
    end else if (step) begin
      cur_addr <= next_addr_c;
      cnt_q    <= cnt_q + LEN_W'(1);
    end
  end

  assign next_addr_c = (cur_addr + AW'(1)) & ADDR_MASK;
  assign last_c      = (cnt_q == len_q);

endmodule

// File: rtl/ram_ctrl.sv
// Burst controller for the single-port synchronous ram block.
// Define RAM_CTRL_INIT_EN to zero-fill the RAM after every reset.
module ram_ctrl
  import ram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  input  logic [DW-1:0]    wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [DW-1:0]    rd_data,
  input  logic             rd_ready,
  output logic             busy,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_rw,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout
);

  state_t        state_q;
  state_t        state_d;
  logic          ag_load;
  logic          ag_step;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] next_addr_c;
  logic          last_c;
  logic [AW-1:0] ram_addr_d;
  logic          ram_rw_d;
  logic [DW-1:0] ram_din_d;
  logic [DW-1:0] rd_data_d;
  logic          rd_valid_d;

  ram_ctrl_addr_gen u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load        (ag_load),
    .step        (ag_step),
    .start       (req_addr),
    .len         (req_len),
    .cur_addr    (cur_addr),
    .next_addr_c (next_addr_c),
    .last_c      (last_c)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    ag_load    = 1'b0;
    ag_step    = 1'b0;
    ram_addr_d = ram_addr;
    ram_rw_d   = RW_READ;
    ram_din_d  = ram_din;
    rd_data_d  = rd_data;
    rd_valid_d = rd_valid;
    case (state_q)
`ifdef RAM_CTRL_INIT_EN
      S_INIT: begin
        ram_addr_d = cur_addr;
        ram_rw_d   = RW_WRITE;
        ram_din_d  = '0;
        ag_step    = 1'b1;
        if (last_c) state_d = S_IDLE;
      end
`endif
      S_IDLE: begin
        if (req_valid && req_ready) begin
          ag_load = 1'b1;
          if (req_write) begin
            state_d = S_WR_BEAT;
          end else begin
            ram_addr_d = req_addr & ADDR_MASK;
            state_d    = S_RD_ISSUE;
          end
        end
      end
      S_WR_BEAT: begin
        if (wr_valid && wr_ready) begin
          ram_addr_d = cur_addr;
          ram_din_d  = wr_data;
          ram_rw_d   = RW_WRITE;
          ag_step    = 1'b1;
          if (last_c) state_d = S_IDLE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // RAM output register now holds the addressed word.
        rd_data_d  = ram_dout;
        rd_valid_d = 1'b1;
        state_d    = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (rd_valid && rd_ready) begin
          rd_valid_d = 1'b0;
          if (last_c) begin
            state_d = S_IDLE;
          end else begin
            ag_step    = 1'b1;
            ram_addr_d = next_addr_c;
            state_d    = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; handshake readies follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef RAM_CTRL_INIT_EN
      state_q <= S_INIT;
      busy    <= 1'b1;
`else
      state_q <= S_IDLE;
      busy    <= 1'b0;
`endif
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      ram_addr  <= '0;
      ram_rw    <= RW_READ;
      ram_din   <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != S_IDLE);
      req_ready <= (state_d == S_IDLE);
      wr_ready  <= (state_d == S_WR_BEAT);
      rd_valid  <= rd_valid_d;
      rd_data   <= rd_data_d;
      ram_addr  <= ram_addr_d;
      ram_rw    <= ram_rw_d;
      ram_din   <= ram_din_d;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed self-checking bench for ram_ctrl with a behavioural model of the
// single-port registered-output RAM; covers the RAM_CTRL_INIT_EN build too.
module tb_ram_ctrl;

`ifdef RAM_CTRL_INIT_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [2:0]  req_len = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ready = 1'b0;
  logic        busy;
  logic [7:0]  ram_addr;
  logic        ram_rw;
  logic [31:0] ram_din;
  logic [31:0] ram_out;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  ram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_rw    (ram_rw),
    .ram_din   (ram_din),
    .ram_dout  (ram_out)
  );

  // Single-port RAM, 8 words, read-first registered output.
  logic [31:0] mem [0:7];
  always @(posedge clk) begin
    if (ram_rw) mem[ram_addr[2:0]] <= ram_din;
    ram_out <= mem[ram_addr[2:0]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_ready();
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_rd_valid();
    for (int i = 0; i < 10 && !rd_valid; i++) tick();
    check("rd_valid_wait", 32'(rd_valid), 32'd1);
  endtask

  // Returns just after the acceptance edge.
  task automatic issue_req(input logic w, input logic [7:0] a, input logic [2:0] l);
    req_write = w;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    wait_req_ready();
    tick();
    req_valid = 1'b0;
  endtask

  task automatic write_beats(input logic [31:0] d[$]);
    foreach (d[i]) begin
      wr_valid = 1'b1;
      wr_data  = d[i];
      for (int k = 0; k < 10 && !wr_ready; k++) tick();
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [31:0] d[$]);
    rd_ready = 1'b1;
    foreach (d[i]) begin
      wait_rd_valid();
      check(tag, rd_data, d[i]);
      tick();
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] wd[4];
    logic [7:0]  wa[4];
    int          t0;
    int          n;
    wd = '{32'h11, 32'h22, 32'h33, 32'h44};
    wa = '{8'd6, 8'd7, 8'd0, 8'd1};

    // Reset values
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'(INIT_EN));
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_rw", 32'(ram_rw), 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    rst = 1'b0;
    wait_req_ready();

    // Single write, then read of the same word accepted the very next cycle
    issue_req(1'b1, 8'd3, 3'd0);
    check("w1_wr_ready", 32'(wr_ready), 32'd1);
    check("w1_busy", 32'(busy), 32'd1);
    check("w1_req_ready", 32'(req_ready), 32'd0);
    check("w1_rw_idle", 32'(ram_rw), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 32'hDEADBEEF;
    tick();
    wr_valid = 1'b0;
    check("w1_rw", 32'(ram_rw), 32'd1);
    check("w1_addr", 32'(ram_addr), 32'd3);
    check("w1_din", ram_din, 32'hDEADBEEF);
    check("w1_done_ready", 32'(req_ready), 32'd1);
    check("w1_done_wr_ready", 32'(wr_ready), 32'd0);
    issue_req(1'b0, 8'h83, 3'd0);
    check("r1_addr_mod", 32'(ram_addr), 32'd3);
    check("r1_rw", 32'(ram_rw), 32'd0);
    check("r1_busy", 32'(busy), 32'd1);
    tick();
    check("r1_valid_e1", 32'(rd_valid), 32'd0);
    tick();
    check("r1_valid_e2", 32'(rd_valid), 32'd1);
    check("r1_data", rd_data, 32'hDEADBEEF);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("r1_valid_drop", 32'(rd_valid), 32'd0);
    check("r1_idle_busy", 32'(busy), 32'd0);
    check("r1_idle_ready", 32'(req_ready), 32'd1);

    // Wrapping write burst 6,7,0,1 with ram_rw held high between beats
    issue_req(1'b1, 8'd6, 3'd3);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = wd[i];
      tick();
      check("wrap_w_addr", 32'(ram_addr), 32'(wa[i]));
      check("wrap_w_rw", 32'(ram_rw), 32'd1);
      check("wrap_w_din", ram_din, wd[i]);
    end
    wr_valid = 1'b0;
    check("wrap_w_ready_end", 32'(wr_ready), 32'd0);
    tick();
    check("wrap_w_rw_drop", 32'(ram_rw), 32'd0);

    // Wrapping read burst at 3 cycles per beat
    issue_req(1'b0, 8'd6, 3'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rd_valid();
      if (i > 0) check("wrap_r_gap", 32'(cyc - t0), 32'd3);
      check("wrap_r_data", rd_data, wd[i]);
      t0 = cyc;
      tick();
    end
    rd_ready = 1'b0;
    check("wrap_r_busy_end", 32'(busy), 32'd0);
    q = {32'h33};
    issue_req(1'b0, 8'd0, 3'd0);
    read_expect("addr0_data", q);

    // Backpressure: response held stable, next beat not issued until handshake
    issue_req(1'b0, 8'd6, 3'd1);
    wait_rd_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(rd_valid), 32'd1);
      check("bp_data", rd_data, 32'h11);
      check("bp_addr", 32'(ram_addr), 32'd6);
    end
    rd_ready = 1'b1;
    tick();
    check("bp_valid_drop", 32'(rd_valid), 32'd0);
    check("bp_next_addr", 32'(ram_addr), 32'd7);
    wait_rd_valid();
    check("bp_data2", rd_data, 32'h22);
    tick();
    rd_ready = 1'b0;
    check("bp_busy_end", 32'(busy), 32'd0);

    // Request offered while a write burst is in progress
    issue_req(1'b1, 8'd2, 3'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'd2;
    req_len   = 3'd0;
    check("busy_req_ready", 32'(req_ready), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 32'hA1;
    tick();
    check("busy_req_ready2", 32'(req_ready), 32'd0);
    check("busy_w_addr0", 32'(ram_addr), 32'd2);
    wr_data = 32'hA2;
    tick();
    wr_valid = 1'b0;
    check("busy_w_addr1", 32'(ram_addr), 32'd3);
    check("busy_w_din1", ram_din, 32'hA2);
    check("busy_req_ready3", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("busy_acc_addr", 32'(ram_addr), 32'd2);
    check("busy_acc_rw", 32'(ram_rw), 32'd0);
    q = {32'hA1};
    read_expect("busy_acc_data", q);

    // Reset asserted once beat 2 of an 8-beat write sits in the RAM registers
    q = {32'hB0, 32'hB1, 32'hB2};
    issue_req(1'b1, 8'd0, 3'd7);
    write_beats(q);
    check("mid_rw_pre", 32'(ram_rw), 32'd1);
    check("mid_addr_pre", 32'(ram_addr), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rw_rst", 32'(ram_rw), 32'd0);
    check("mid_busy_rst", 32'(busy), 32'(INIT_EN));
    check("mid_wr_ready_rst", 32'(wr_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("mid_busy_rel", 32'(busy), 32'(INIT_EN));
    check("mid_ready_rel", 32'(req_ready), 32'(!INIT_EN));
    if (INIT_EN) q = {32'h0, 32'h0, 32'h0, 32'h0};
    else         q = {32'hB0, 32'hB1, 32'hA1, 32'hA2};
    issue_req(1'b0, 8'd0, 3'd3);
    read_expect("mid_readback", q);

`ifdef RAM_CTRL_INIT_EN
    // Fill with nonzero data, reset, and expect an 8-cycle zero-fill
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(32'hC0 + 32'(i));
    issue_req(1'b1, 8'd0, 3'd7);
    write_beats(q);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("init_busy_rst", 32'(busy), 32'd1);
    check("init_ready_rst", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    n = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) n++;
      else break;
    end
    check("init_busy_cycles", 32'(n), 32'd8);
    check("init_ready_end", 32'(req_ready), 32'd1);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(32'h0);
    issue_req(1'b0, 8'd0, 3'd7);
    read_expect("init_zero", q);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
